// File: rtl/seven_seg_pkg.sv
// Shared types and sizes for the multiplexed four-digit seven-segment display.
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;

  typedef logic [NIBBLE_W-1:0]   nibble_t;
  typedef logic [NUM_DIGITS-1:0] digit_mask_t;

  typedef struct packed {
    logic [NUM_DIGITS*NIBBLE_W-1:0] value;
    digit_mask_t                    en;
    digit_mask_t                    dp;
    logic                           lz;
  } disp_t;
endpackage

// File: rtl/seven_segment_scanner_scan_timer.sv
// Slot timer: steps the selected digit every DIGIT_CYCLES clocks and flags the
// blanking window at the start of each slot plus the final cycle of digit 3.
module scan_timer #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] sel,
  output logic       blank,
  output logic       wrap
);
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic             w_tc;

  assign w_tc = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sel   = r_sel;
  assign blank = (r_cnt < BLANK_END);
  assign wrap  = w_tc && (r_sel == 2'd3);
endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit display scanner: double-buffers the display data so it only
// changes at a frame boundary, and drives registered anode/nibble/dp outputs.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame
);
  logic [1:0]  w_sel;
  logic        w_blank;
  logic        w_wrap;
  disp_t       w_live;
  disp_t       r_disp;
  disp_t       r_pend;
  logic        r_busy;
  digit_mask_t w_supp;
  digit_mask_t w_an;
  nibble_t     r_digit;
  digit_mask_t r_an;
  logic        r_dp_n;
  logic        r_frame;

  scan_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .sel  (w_sel),
    .blank(w_blank),
    .wrap (w_wrap)
  );

  assign w_live = '{value: value, en: digit_en, dp: dp_in, lz: lz_en};

  // A load on the wrap edge bypasses the pending buffer so no busy pulse appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= '0;
      r_pend <= '0;
      r_busy <= 1'b0;
    end else begin
      if (load) r_pend <= w_live;
      if (w_wrap) begin
        if (load)        r_disp <= w_live;
        else if (r_busy) r_disp <= r_pend;
        r_busy <= 1'b0;
      end else if (load) begin
        r_busy <= 1'b1;
      end
    end
  end

  always_comb begin
    w_supp    = '0;
    w_supp[3] = r_disp.lz && (r_disp.value[15:12] == 4'd0);
    w_supp[2] = r_disp.lz && (r_disp.value[15:8]  == 8'd0);
    w_supp[1] = r_disp.lz && (r_disp.value[15:4]  == 12'd0);
  end

  always_comb begin
    w_an = '1;
    if (!w_blank && r_disp.en[w_sel] && !w_supp[w_sel]) w_an[w_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
      r_an    <= '1;
      r_dp_n  <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_digit <= r_disp.value[{w_sel, 2'b00} +: 4];
      r_an    <= w_an;
      r_dp_n  <= w_blank ? 1'b1 : ~r_disp.dp[w_sel];
      r_frame <= w_wrap;
    end
  end

  assign busy  = r_busy;
  assign digit = r_digit;
  assign an    = r_an;
  assign dp_n  = r_dp_n;
  assign frame = r_frame;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed and randomized checks of the display scanner against a frame-level model.
module tb_seven_segment_scanner;
  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic        busy, dp_n, frame;
  logic [3:0]  digit, an;

  int n_assert = 0;
  int n_fail = 0;

  // model state: m_k = clock edges since reset released
  int          m_k = 0;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_en = '0, m_dp = '0, p_en = '0, p_dp = '0;
  logic        m_lz = 1'b0, p_lz = 1'b0, m_busy = 1'b0;
  logic [3:0]  e_an, e_digit;
  logic        e_dp, e_frame;

  seven_segment_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .lz_en(lz_en), .load(load), .busy(busy), .digit(digit), .an(an),
    .dp_n(dp_n), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, m_k, obs, exp);
    end
  endtask

  task automatic step();
    int slot, c;
    logic lit, wr, sup;
    if (rst) begin
      m_k = 0; m_val = '0; m_en = '0; m_dp = '0; m_lz = 1'b0;
      p_val = '0; p_en = '0; p_dp = '0; p_lz = 1'b0; m_busy = 1'b0;
      e_an = 4'hF; e_digit = 4'h0; e_dp = 1'b1; e_frame = 1'b0;
    end else begin
      slot = (m_k / DC) % 4;
      c    = m_k % DC;
      lit  = (c >= BC);
      wr   = (slot == 3) && (c == DC - 1);
      sup  = (slot != 0) && m_lz && ((m_val >> (4 * slot)) == 16'd0);
      e_digit = m_val[4*slot +: 4];
      e_an = 4'hF;
      if (lit && m_en[slot] && !sup) e_an[slot] = 1'b0;
      e_dp = lit ? ~m_dp[slot] : 1'b1;
      e_frame = wr;
      if (wr) begin
        if (load) begin
          m_val = value; m_en = digit_en; m_dp = dp_in; m_lz = lz_en;
        end else if (m_busy) begin
          m_val = p_val; m_en = p_en; m_dp = p_dp; m_lz = p_lz;
        end
        m_busy = 1'b0;
      end else if (load) begin
        m_busy = 1'b1;
      end
      if (load) begin
        p_val = value; p_en = digit_en; p_dp = dp_in; p_lz = lz_en;
      end
      m_k++;
    end
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    chk("digit", digit, e_digit);
    chk("dp_n", {3'b000, dp_n}, {3'b000, e_dp});
    chk("frame", {3'b000, frame}, {3'b000, e_frame});
    chk("busy", {3'b000, busy}, {3'b000, m_busy});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int slot, input int c);
    for (int n = 0; n <= 4 * DC; n++) begin
      if (((m_k / DC) % 4 == slot) && (m_k % DC == c)) return;
      step();
    end
    n_assert++;
    n_fail++;
    $error("FAIL run_to observed=timeout expected=slot%0d_cnt%0d", slot, c);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] dp, input logic lz);
    value = v; digit_en = en; dp_in = dp; lz_en = lz;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // basic scan of 1234
    do_load(16'h1234, 4'hF, 4'h0, 1'b0);
    run(4 * DC * 2);

    // mid-frame load stays pending until wrap
    run_to(1, 3);
    do_load(16'hABCD, 4'hF, 4'h0, 1'b0);
    run(4 * DC + 4);

    // two loads in one frame, last wins
    run_to(0, 5);
    do_load(16'h1111, 4'hF, 4'h0, 1'b0);
    run_to(2, 1);
    do_load(16'h2222, 4'hF, 4'h0, 1'b0);
    run(4 * DC + 4);

    // load coincident with wrap edge
    run_to(3, DC - 1);
    do_load(16'h5A5A, 4'hF, 4'h3, 1'b0);
    run(4 * DC);

    // leading-zero suppression
    run_to(1, 0);
    do_load(16'h0050, 4'hF, 4'h0, 1'b1);
    run(4 * DC * 2);
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    run(4 * DC * 2);

    // digit enables and decimal point
    do_load(16'h9876, 4'b0101, 4'b0100, 1'b0);
    run(4 * DC * 2);

    // randomized loads
    for (int r = 0; r < 30; r++) begin
      logic lz;
      logic [15:0] v;
      lz = 1'($urandom_range(0, 1));
      v  = lz ? 16'($urandom_range(0, 255)) << (4 * $urandom_range(0, 2)) : 16'($urandom);
      run($urandom_range(1, 24));
      do_load(v, 4'($urandom), 4'($urandom), lz);
    end
    run(4 * DC * 2);

    // reset mid-frame with an update pending
    run_to(2, 4);
    do_load(16'hFEED, 4'hF, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(4 * DC + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
